// File: rtl/fifo_sc_pkt_reader.sv
// Drains a registered-read single-clock FIFO into a valid/ready packet stream.
// A 2-entry skid buffer plus credit-gated reads hide the one-cycle read latency.
module fifo_sc_pkt_reader #(
  parameter int W     = 16,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             fifo_read,
  input  logic [W-1:0]     fifo_data_out,
  input  logic             fifo_valid_out,
  input  logic             fifo_empty,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [W-1:0]     m_data,
  output logic             m_last
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t           state_q;
  logic [LEN_W-1:0] issue_rem_q;
  logic [LEN_W-1:0] land_rem_q;
  logic [1:0]       count_q;
  logic [W-1:0]     head_data_q;
  logic             head_last_q;
  logic [W-1:0]     tail_data_q;
  logic             tail_last_q;
  logic             busy_q;
  logic             done_q;

  logic             pop;
  logic             push;
  logic             new_last;
  logic [2:0]       level_d;

  assign pop      = (count_q != '0) && m_ready;
  assign push     = fifo_valid_out && (state_q != IDLE);
  assign new_last = (land_rem_q == LEN_W'(1));

  // Occupancy after this edge; a read issued now lands next cycle, so it must fit.
  assign level_d  = {1'b0, count_q} + {2'b0, push} - {2'b0, pop};

  assign fifo_read = !rst && (state_q == RUN) && !fifo_empty &&
                     (issue_rem_q != '0) && (level_d < 3'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      issue_rem_q <= '0;
      land_rem_q  <= '0;
      count_q     <= '0;
      head_data_q <= '0;
      head_last_q <= 1'b0;
      tail_data_q <= '0;
      tail_last_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && (len != '0)) begin
            issue_rem_q <= len;
            land_rem_q  <= len;
            busy_q      <= 1'b1;
            state_q     <= RUN;
          end
        end
        RUN: begin
          if (fifo_read) begin
            issue_rem_q <= issue_rem_q - LEN_W'(1);
            if (issue_rem_q == LEN_W'(1)) state_q <= FLUSH;
          end
        end
        default: ;
      endcase

      if ((state_q != IDLE) && pop && head_last_q) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
      end

      if (push) land_rem_q <= land_rem_q - LEN_W'(1);

      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_data_q <= fifo_data_out;
            head_last_q <= new_last;
          end else begin
            tail_data_q <= fifo_data_out;
            tail_last_q <= new_last;
          end
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_data_q <= tail_data_q;
          head_last_q <= tail_last_q;
          count_q     <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_data_q <= fifo_data_out;
            head_last_q <= new_last;
          end else begin
            head_data_q <= tail_data_q;
            head_last_q <= tail_last_q;
            tail_data_q <= fifo_data_out;
            tail_last_q <= new_last;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign m_valid = (count_q != '0);
  assign m_data  = head_data_q;
  assign m_last  = head_last_q;

endmodule

// File: tb/tb_fifo_sc_pkt_reader.sv
// Bench for fifo_sc_pkt_reader: FIFO model, packet-level reference model, directed + random packets.
module tb_fifo_sc_pkt_reader;
  localparam int W  = 16;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic          busy, done, fifo_read;
  logic [W-1:0]  fifo_data_out = '0;
  logic          fifo_valid_out = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [W-1:0]  m_data;
  logic          m_last;

  fifo_sc_pkt_reader #(.W(W), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy), .done(done),
    .fifo_read(fifo_read), .fifo_data_out(fifo_data_out),
    .fifo_valid_out(fifo_valid_out), .fifo_empty(fifo_empty),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // FIFO: registered read data one cycle after read, registered empty flag.
  logic [W-1:0] fq[$];
  logic [W-1:0] wq[$];
  always @(posedge clk) begin
    if (rst) begin
      fq.delete();
      wq.delete();
      fifo_valid_out <= 1'b0;
      fifo_empty     <= 1'b1;
    end else begin
      if (fifo_read && fq.size() > 0) begin
        fifo_data_out  <= fq.pop_front();
        fifo_valid_out <= 1'b1;
      end else begin
        fifo_valid_out <= 1'b0;
      end
      while (wq.size() > 0) fq.push_back(wq.pop_front());
      fifo_empty <= (fq.size() == 0);
    end
  end

  // Reference model: words leave in FIFO write order, last on the len-th of each packet.
  logic [W-1:0] exp_q[$];
  bit           mdl_busy, mdl_done, nb, nd, el;
  bit           prev_stall;
  logic [W-1:0] prev_data, e;
  logic         prev_last;
  int cyc = 0, k = 0, cur_len = 0, rd_cnt = 0, landed = 0, popped = 0;
  int first_rd = -1, first_v = -1, hs_first = 0, hs_last = 0;
  int done_cnt = 0, last_cnt = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk(32'(fifo_read), 0, "rd_in_rst");
      mdl_busy = 0; mdl_done = 0; exp_q.delete();
      k = 0; cur_len = 0; rd_cnt = 0; landed = 0; popped = 0;
      prev_stall = 0; first_rd = -1; first_v = -1;
    end else begin
      chk(32'(busy), 32'(mdl_busy), "busy");
      chk(32'(done), 32'(mdl_done), "done");
      if (!mdl_busy) chk(32'(m_valid), 0, "idle_valid");
      if (prev_stall) chk({14'd0, m_valid, m_last, m_data}, {14'd0, 1'b1, prev_last, prev_data}, "hold");
      if (fifo_read) begin
        rd_cnt++;
        chk(32'(mdl_busy && rd_cnt <= cur_len), 1, "rd_bound");
        chk(32'(fifo_empty), 0, "rd_empty");
        if (first_rd < 0) first_rd = cyc;
      end
      if (m_valid && first_v < 0) begin
        first_v = cyc;
        chk(32'(first_v - first_rd), 2, "first_latency");
      end
      if (fifo_valid_out) landed++;
      nb = mdl_busy; nd = 0;
      if (m_valid && m_ready) begin
        chk(32'(mdl_busy && exp_q.size() > 0), 1, "hs_expected");
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          k++;
          el = (k == cur_len);
          chk(32'(m_data), 32'(e), "data");
          chk(32'(m_last), 32'(el), "last");
          if (m_last) last_cnt++;
          if (k == 1) hs_first = cyc;
          hs_last = cyc;
          popped++;
          if (el) begin
            nb = 0; nd = 1; done_cnt++;
            chk(32'(rd_cnt), 32'(cur_len), "rd_total");
          end
        end
      end else if (!mdl_busy && start && len != 0) begin
        nb = 1; cur_len = int'(len); k = 0; rd_cnt = 0; first_rd = -1; first_v = -1;
      end
      chk(32'(landed - popped >= 0 && landed - popped <= 2), 1, "occupancy");
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      mdl_busy = nb;
      mdl_done = nd;
    end
  end

  // 0: always ready, 1: alternate, 2: random
  int rdy_mode = 0;
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1:       m_ready = ~m_ready;
        2:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b1;
      endcase
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_word(input logic [W-1:0] w);
    wq.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic start_pkt(input int l);
    start = 1'b1; len = LW'(l);
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string tag);
    int n = 0;
    while (!done && n < limit) begin step(); n++; end
    chk(32'(done), 1, tag);
  endtask

  int d0, l0, got, pushed, plen;

  initial begin
    step(3);
    chk(32'(busy), 0, "rst_busy");
    chk(32'(done), 0, "rst_done");
    chk(32'(m_valid), 0, "rst_valid");
    chk(32'(m_last), 0, "rst_last");
    chk(32'(m_data), 0, "rst_data");
    rst = 1'b0;

    // len=4, preloaded A0..A3, always ready
    for (int i = 0; i < 4; i++) push_word(W'(16'hA0 + i));
    step(2);
    d0 = done_cnt;
    start_pkt(4);
    wait_done(50, "t1_done_timeout");
    chk(32'(hs_last - hs_first), 3, "t1_consecutive");
    chk(32'(done_cnt - d0), 1, "t1_one_packet");
    step();
    chk(32'(done), 0, "t1_done_pulse");
    chk(32'(busy), 0, "t1_busy_clear");

    // len=8 with alternating ready
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) push_word(W'($urandom));
    start_pkt(8);
    wait_done(100, "t2_done_timeout");
    rdy_mode = 0;
    step(2);

    // len=5 with FIFO running dry after 2 words
    push_word(W'($urandom)); push_word(W'($urandom));
    start_pkt(5);
    step(10);
    chk(32'(m_valid), 0, "t3_paused");
    chk(32'(busy), 1, "t3_still_busy");
    chk(32'(k), 2, "t3_words_before_pause");
    for (int i = 0; i < 3; i++) push_word(W'($urandom));
    wait_done(50, "t3_done_timeout");
    step(2);

    // len=0 ignored; start during busy ignored
    d0 = done_cnt;
    start_pkt(0);
    step(3);
    chk(32'(busy), 0, "t4_len0_busy");
    chk(32'(done_cnt - d0), 0, "t4_len0_no_done");
    rdy_mode = 2;
    for (int i = 0; i < 6; i++) push_word(W'($urandom));
    start_pkt(6);
    step(2);
    start_pkt(3);
    wait_done(100, "t4_done_timeout");
    chk(32'(exp_q.size()), 0, "t4_all_delivered");
    rdy_mode = 0;
    step(2);

    // back-to-back: len=1 then start in the done cycle with len=2
    d0 = done_cnt; l0 = last_cnt;
    for (int i = 0; i < 3; i++) push_word(W'($urandom));
    step(2);
    start_pkt(1);
    wait_done(50, "t5a_done_timeout");
    start_pkt(2);
    wait_done(50, "t5b_done_timeout");
    chk(32'(done_cnt - d0), 2, "t5_two_done");
    chk(32'(last_cnt - l0), 2, "t5_two_last");
    step(2);

    // reset mid-packet
    for (int i = 0; i < 10; i++) push_word(W'($urandom));
    step(2);
    start_pkt(10);
    got = 0;
    while (k < 3 && got < 50) begin step(); got++; end
    chk(32'(k), 3, "t6_three_words");
    rst = 1'b1;
    step();
    chk(32'(m_valid), 0, "t6_rst_valid");
    chk(32'(busy), 0, "t6_rst_busy");
    rst = 1'b0;
    step();
    push_word(W'($urandom)); push_word(W'($urandom));
    step(2);
    start_pkt(2);
    wait_done(50, "t6_done_timeout");
    chk(32'(exp_q.size()), 0, "t6_all_delivered");
    step(2);

    // random packets with random ready and trickling writes
    rdy_mode = 2;
    for (int p = 0; p < 6; p++) begin
      plen = int'($urandom_range(1, 12));
      pushed = 0;
      start_pkt(plen);
      got = 0;
      while (!done && got < 400) begin
        if (pushed < plen && $urandom_range(0, 2) == 0) begin
          push_word(W'($urandom));
          pushed++;
        end
        step();
        got++;
      end
      chk(32'(done), 1, "rand_done_timeout");
    end
    rdy_mode = 0;
    step(3);
    chk(32'(exp_q.size()), 0, "rand_all_delivered");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fifo_sc_pkt_reader.md
Name: fifo_sc_pkt_reader

Overview:
Drains a single-clock FIFO (registered read data, one-cycle read latency, valid_out flag) into a valid/ready stream, framing a programmed number of words as one packet with last on the final word. A 2-entry skid buffer with credit-based read issue absorbs the FIFO read latency, so it sustains one word per cycle under continuous ready. It sits on the read side of fifo_sc, feeding downstream packet consumers.

Parameters:
W, 16, data width; matches FIFO W.
LEN_W, 16, width of packet length in words.

Ports:
clk  input  1  clock.
rst  input  1  reset, synchronous, active-high.
start  input  1  pulse: begin a packet of len words.
len  input  LEN_W  packet length in words, sampled with start.
busy  output  1  high from accepted start until done.
done  output  1  one-cycle pulse after the final word handshake.
fifo_read  output  1  FIFO read strobe.
fifo_data_out  input  W  FIFO read data, valid when fifo_valid_out.
fifo_valid_out  input  1  FIFO read-data valid (one cycle after read while not empty).
fifo_empty  input  1  FIFO empty flag.
m_valid  output  1  stream word valid.
m_ready  input  1  stream consumer ready.
m_data  output  W  stream word.
m_last  output  1  final word of packet; qualified by m_valid.

Behaviour:
- Reset: state IDLE; busy, done, m_valid, m_last = 0; m_data = 0; buffer count = 0; all counters = 0. fifo_read is 0 during reset.
- States: IDLE, RUN, FLUSH.
- IDLE: start && len != 0 -> latch len into issue_rem and land_rem; busy = 1 next cycle; go RUN. start with len == 0 is ignored. start while busy is ignored.
- RUN: pop = m_valid && m_ready.
- fifo_read (combinational) = RUN && !fifo_empty && issue_rem != 0 && (count + fifo_valid_out - pop) < 2.
- On each fifo_read, issue_rem decrements; when it reaches 0, go FLUSH.
- FLUSH: no further reads. Go IDLE after the handshake of the word carrying m_last.
- Landing: when fifo_valid_out, write {fifo_data_out, land_rem == 1} into the buffer tail and decrement land_rem. A landing while the buffer holds 2 entries is a design error; the credit rule above prevents it (assert in bench).
- Buffer: 2-entry register FIFO. m_valid = count != 0. m_data/m_last come from the head entry and are registered outputs. Push and pop in the same cycle leave count unchanged.
- Handshake: a word transfers on m_valid && m_ready. m_data and m_last are held stable while m_valid && !m_ready.
- Final handshake (m_last && m_ready): done = 1 next cycle for exactly one cycle; busy = 0 in that same cycle; state IDLE. A new start is accepted in that cycle.
- Throughput: with fifo non-empty and m_ready held high, one word per cycle after a 2-cycle fill latency. The first m_valid appears 2 cycles after the first fifo_read.
- FIFO going empty mid-packet: reads stall and resume when not empty; no words are lost or duplicated.
- Counter widths: issue_rem and land_rem are LEN_W bits. len = 2^LEN_W-1 is supported; no wrap.
- Reset mid-packet: returns to the reset state immediately. In-flight FIFO data landing in the reset cycle is discarded. The FIFO is reset separately by its owner.

Test Plan:
- Reset then start, len=4, FIFO preloaded 0xA0..0xA3, m_ready=1 -> m_data A0,A1,A2,A3 on consecutive cycles, m_last only on A3; done pulse 1 cycle later; fifo_read asserted exactly 4 times.
- len=8, m_ready toggling 1,0,1,0 -> 8 words in order, m_data stable while stalled, buffer count never exceeds 2, no fifo_read beyond 8.
- len=5, FIFO holds 2 words, remaining 3 written 10 cycles later -> stream pauses (m_valid=0) then resumes; exactly 5 words, last on the 5th.
- start with len=0 -> no busy, no fifo_read, no done. start pulsed again while busy with len=3 during len=6 -> ignored, 6 words delivered.
- Back-to-back: len=1 then start in the done cycle with len=2 -> m_last on word 1 and on word 3; two done pulses.
- rst asserted after 3 of 10 words delivered -> m_valid, busy = 0 next cycle; after rst, start len=2 works normally.
